// File: rtl/bin2bcd_disp_if.sv
// rtl/bin2bcd_disp_if.sv - start/done conversion handshake and display-word bus for bin2bcd_disp
interface bin2bcd_disp_if #(
  parameter int BIN_W = 14
);
  logic             start;
  logic [BIN_W-1:0] binIn;
  logic [3:0]       pointIn;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [15:0]      dispVal;
  logic [3:0]       point;

  modport master (
    output start, binIn, pointIn,
    input  busy, done, ovf, dispVal, point
  );

  modport slave (
    input  start, binIn, pointIn,
    output busy, done, ovf, dispVal, point
  );
endinterface

// File: rtl/bin2bcd_disp.sv
// rtl/bin2bcd_disp.sv - sequential double-dabble binary-to-BCD converter feeding the 7-segment display
// Optional macro OVERFLOW_SAT_EN: saturate dispVal to 16'h9999 when the input exceeds 9999.
module bin2bcd_disp #(
  parameter int BIN_W = 14
) (
  input  logic          clk5,
  input  logic          reset,
  bin2bcd_disp_if.slave bus
);
  localparam int SR_W  = 20 + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d, sr_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       pt_lat_q, pt_lat_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [15:0]      disp_q, disp_d;
  logic [3:0]       point_q, point_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             bin_over;
  logic [15:0]      disp_res;

  assign bin_over = 32'(bus.binIn) > 32'd9999;

  // Add-3 correction on every BCD nibble before the shift.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 5; i++) begin
      if (sr_q[BIN_W + 4*i +: 4] >= 4'd5)
        sr_adj[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
    end
  end

`ifdef OVERFLOW_SAT_EN
  assign disp_res = ovf_pend_q ? 16'h9999 : sr_q[BIN_W +: 16];
`else
  assign disp_res = sr_q[BIN_W +: 16];
`endif

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    pt_lat_d   = pt_lat_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    point_d    = point_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sr_d       = SR_W'(bus.binIn);
          pt_lat_d   = bus.pointIn;
          ovf_pend_d = bin_over;
          cnt_d      = '0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d  = sr_adj << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST)
          state_d = S_DONE;
      end
      S_DONE: begin
        disp_d  = disp_res;
        point_d = pt_lat_q;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      pt_lat_q   <= 4'b0000;
      ovf_pend_q <= 1'b0;
      disp_q     <= 16'h0000;
      point_q    <= 4'b0000;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      pt_lat_q   <= pt_lat_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      point_q    <= point_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;
  assign bus.dispVal = disp_q;
  assign bus.point   = point_q;
endmodule
